// File: rtl/ctrl_encode_def.sv
// Shared encodings for the tiny-CPU control path: fetch FSM states and the
// default reset PC.
package ctrl_encode_def;

  typedef enum logic {
    IF_REQ  = 1'b0,
    IF_WAIT = 1'b1
  } if_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode
// output channel of the fetch unit.
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch front end: one outstanding imem read, one-entry output register to
// decode, redirects squash in-flight or buffered wrong-path fetches.
module ifetch_unit
  import ctrl_encode_def::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  ifetch_unit_if.master bus,
  output logic [31:0]   pc_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        req_valid;
  logic        slot_free;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    req_valid  = 1'b0;
    slot_free  = !if_valid_q || bus.if_ready;

    case (state_q)
      IF_REQ: begin
        // rstn gate keeps the request low while reset is held
        req_valid = rstn && slot_free && !redirect;
        if (if_valid_q && bus.if_ready) begin
          if_valid_d = 1'b0;
        end
        if (req_valid && bus.imem_req_ready) begin
          state_d = IF_WAIT;
          drop_d  = 1'b0;
        end
      end
      IF_WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_d = IF_REQ;
          drop_d  = 1'b0;
          if (!drop_q) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = bus.imem_rsp_data;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      default: state_d = IF_REQ;
    endcase

    // Redirect overrides everything; a response still owed becomes stale.
    if (redirect) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if (state_q == IF_WAIT && !bus.imem_rsp_valid) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IF_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign pc_o               = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a small imem responder with programmable
// latency, and hand-computed expectations for each cycle of interest.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_o;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC(32'h0000_3000)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (bus),
    .pc_o       (pc_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 1;
  bit          pend = 1'b0;
  int          age = 0;
  logic [31:0] paddr = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; memory answers `lat` cycles after acceptance.
  task automatic tick();
    bit          acc;
    bit          fire;
    logic [31:0] a;
    #1;
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    fire = bus.imem_rsp_valid;
    a    = bus.imem_addr;
    @(posedge clk);
    @(negedge clk);
    if (!rstn) begin
      pend = 1'b0;
    end else begin
      if (fire) pend = 1'b0;
      if (acc) begin
        pend  = 1'b1;
        age   = 1;
        paddr = a;
      end else if (pend) begin
        age++;
      end
    end
    bus.imem_rsp_valid = pend && (age >= lat);
    bus.imem_rsp_data  = (pend && (age >= lat)) ? (paddr ^ 32'hDEAD_0000) : 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.if_ready       = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("rst_pc_o", pc_o, 32'h0000_3000);
    check_eq("rst_addr", bus.imem_addr, 32'h0000_3000);
    check_eq("rst_if_pc", bus.if_pc, 32'h0);
    check_eq("rst_if_instr", bus.if_instr, 32'h0);

    @(negedge clk);
    rstn = 1'b1;

    // Streaming, k=1: requests every 2 cycles, output trails by 2
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("str_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("str_addr", bus.imem_addr, 32'h0000_3000 + 32'(4 * i));
      if (i > 0) begin
        check_eq("str_if_valid", 32'(bus.if_valid), 32'd1);
        check_eq("str_if_pc", bus.if_pc, 32'h0000_3000 + 32'(4 * (i - 1)));
        check_eq("str_if_instr", bus.if_instr, 32'hDEAD_3000 + 32'(4 * (i - 1)));
      end
      tick();
      #1;
      check_eq("str_wait_req", 32'(bus.imem_req_valid), 32'd0);
      check_eq("str_wait_if_valid", 32'(bus.if_valid), 32'd0);
      tick();
    end

    // Decode stall holds the output and blocks new requests
    bus.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("stall_if_valid", 32'(bus.if_valid), 32'd1);
      check_eq("stall_if_pc", bus.if_pc, 32'h0000_3008);
      check_eq("stall_if_instr", bus.if_instr, 32'hDEAD_3008);
      check_eq("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      tick();
    end
    bus.if_ready = 1'b1;
    #1;
    check_eq("unstall_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("unstall_addr", bus.imem_addr, 32'h0000_300C);
    tick();
    #1;
    check_eq("unstall_wait_if_valid", 32'(bus.if_valid), 32'd0);
    tick();
    #1;
    check_eq("next_if_valid", 32'(bus.if_valid), 32'd1);
    check_eq("next_if_pc", bus.if_pc, 32'h0000_300C);
    check_eq("next_addr", bus.imem_addr, 32'h0000_3010);
    lat = 3;
    tick();

    // Redirect in WAIT: the late response must be dropped
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3400;
    #1;
    check_eq("rdw_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("rdw_pc_o", pc_o, 32'h0000_3400);
    check_eq("rdw_if_valid", 32'(bus.if_valid), 32'd0);
    tick();
    #1;
    check_eq("rdw_stale_req", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rdw_stale_if_valid", 32'(bus.if_valid), 32'd0);
    tick();
    #1;
    check_eq("rdw_drop_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("rdw_req_valid2", 32'(bus.imem_req_valid), 32'd1);
    check_eq("rdw_addr", bus.imem_addr, 32'h0000_3400);
    lat = 1;
    tick();

    // Redirect coincident with the response; target low bits masked
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3801;
    #1;
    check_eq("rdr_rsp_present", 32'(bus.imem_rsp_valid), 32'd1);
    check_eq("rdr_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("rdr_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("rdr_req_valid2", 32'(bus.imem_req_valid), 32'd1);
    check_eq("rdr_addr", bus.imem_addr, 32'h0000_3800);

    // Memory back-pressure keeps the request stable
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("bp_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("bp_addr", bus.imem_addr, 32'h0000_3800);
      tick();
    end
    bus.imem_req_ready = 1'b1;
    #1;
    check_eq("bp_acc_addr", bus.imem_addr, 32'h0000_3800);
    tick();
    tick();
    #1;
    check_eq("bp_if_valid", 32'(bus.if_valid), 32'd1);
    check_eq("bp_if_pc", bus.if_pc, 32'h0000_3800);
    check_eq("bp_if_instr", bus.if_instr, 32'hDEAD_3800);

    // Redirect in REQ: request to target the next cycle
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3010;
    #1;
    check_eq("rdq_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("rdq_req_valid2", 32'(bus.imem_req_valid), 32'd1);
    check_eq("rdq_addr", bus.imem_addr, 32'h0000_3010);
    lat = 3;
    tick();

    // Reset in the middle of WAIT
    #1;
    check_eq("mid_pc_o", pc_o, 32'h0000_3010);
    rstn = 1'b0;
    pend = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    #1;
    check_eq("mrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("mrst_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("mrst_pc_o", pc_o, 32'h0000_3000);
    check_eq("mrst_addr", bus.imem_addr, 32'h0000_3000);
    check_eq("mrst_if_pc", bus.if_pc, 32'h0);
    check_eq("mrst_if_instr", bus.if_instr, 32'h0);
    lat = 1;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check_eq("post_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("post_addr", bus.imem_addr, 32'h0000_3000);
    tick();
    #1;
    check_eq("post_wait_if_valid", 32'(bus.if_valid), 32'd0);
    tick();
    #1;
    check_eq("post_if_valid", 32'(bus.if_valid), 32'd1);
    check_eq("post_if_pc", bus.if_pc, 32'h0000_3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
